// File: rtl/ucc_serial_seq.sv
// ucc_serial_seq: bit-serial sequencer for one 1-bit universal cell (UCC1Bit).
// A multi-bit operation runs over N cycles. Operands go to the cell LSB-first,
// the carry is held between steps, and the fout bits are collected into result.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   start                    request; accepted only in IDLE or DONE
//   mode, cin0, a, b         operation inputs, latched when start is accepted
//   cell_fin/pin/cin/m       drives to the cell; 0 outside RUN
//   cell_fout/cout/mo        returns from the cell
//   busy                     high while in RUN
//   done                     one-cycle pulse in DONE
//   result, carry_out        assembled result and final carry
//   err                      sticky flag: the cell's mode echo did not match
module ucc_serial_seq #(
   parameter int unsigned N  = 4,
   parameter int unsigned CW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    mode,
   input  logic          cin0,
   input  logic [N-1:0]  a,
   input  logic [N-1:0]  b,
   output logic          cell_fin,
   output logic          cell_pin,
   output logic          cell_cin,
   output logic [1:0]    cell_m,
   input  logic          cell_fout,
   input  logic          cell_cout,
   input  logic [1:0]    cell_mo,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  result,
   output logic          carry_out,
   output logic          err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            accept;
   logic            last_step;
   logic [N-1:0]    a_sr, b_sr;
   logic [1:0]      m_r;
   logic            c_r;
   logic [CW-1:0]   cnt;

   assign last_step = (cnt == CW'(N - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next state and start acceptance
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (last_step) state_nxt = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = S_RUN;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand shifting, carry hold, result assembly and mode-echo check
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr      <= '0;
         b_sr      <= '0;
         m_r       <= '0;
         c_r       <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         err       <= 1'b0;
      end else if (accept) begin
         a_sr   <= a;
         b_sr   <= b;
         m_r    <= mode;
         c_r    <= cin0;
         cnt    <= '0;
         result <= '0;
         err    <= 1'b0;
      end else if (state == S_RUN) begin
         result <= {cell_fout, result[N-1:1]};
         c_r    <= cell_cout;
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         cnt    <= cnt + CW'(1);
         if (cell_mo != m_r) err <= 1'b1;
         if (last_step) carry_out <= cell_cout;
      end
   end

   // Status decoded from the state register
   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   // Cell drives come from registers only, so there is no loop through the cell
   assign cell_fin = busy ? a_sr[0] : 1'b0;
   assign cell_pin = busy ? b_sr[0] : 1'b0;
   assign cell_cin = busy ? c_r     : 1'b0;
   assign cell_m   = busy ? m_r     : 2'b00;

endmodule

// File: tb/tb_ucc_serial_seq.sv
// tb_ucc_serial_seq: randomized and directed bench for ucc_serial_seq, using a
// full-adder cell stub. Expected values come from integer addition of the
// operands and from carry propagation computed bit by bit.
module tb_ucc_serial_seq;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    mode;
   logic          cin0;
   logic [N-1:0]  a, b;
   logic          cell_fin, cell_pin, cell_cin;
   logic [1:0]    cell_m;
   logic          cell_fout, cell_cout;
   logic [1:0]    cell_mo;
   logic          busy, done, carry_out, err;
   logic [N-1:0]  result;
   logic          flip;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Cell stub: a full adder, with an optional corrupted mode echo
   assign cell_fout = cell_fin ^ cell_pin ^ cell_cin;
   assign cell_cout = (cell_fin & cell_pin) | (cell_fin & cell_cin) | (cell_pin & cell_cin);
   assign cell_mo   = cell_m ^ {1'b0, flip};

   ucc_serial_seq #(.N(N), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .cin0(cin0),
      .a(a), .b(b),
      .cell_fin(cell_fin), .cell_pin(cell_pin), .cell_cin(cell_cin), .cell_m(cell_m),
      .cell_fout(cell_fout), .cell_cout(cell_cout), .cell_mo(cell_mo),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_drives_zero(input string tag);
      chk({tag, ".drv"}, 32'({cell_fin, cell_pin, cell_cin, cell_m}), 32'd0);
   endtask

   // One operation. flip_step: step with a bad mode echo (-1 = none).
   // glitch_step: step where start is re-pulsed with a=all ones (-1 = none).
   // rst_step: step where reset aborts the run (-1 = none).
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tbv, input logic tc,
                         input logic [1:0] tm, input int flip_step, input int glitch_step,
                         input int rst_step);
      logic [N:0] sum;
      logic       c;
      logic [N-1:0] res_hold;
      @(negedge clk);
      a = ta; b = tbv; cin0 = tc; mode = tm; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = N'($urandom); b = N'($urandom); cin0 = 1'($urandom); mode = 2'($urandom);
      c = tc;
      for (int i = 0; i < int'(N); i++) begin
         if (i == rst_step) begin
            rst = 1'b1;
            #1;
            chk("abort.busy", 32'(busy), 32'd0);
            chk("abort.done", 32'(done), 32'd0);
            chk("abort.result", 32'(result), 32'd0);
            chk("abort.carry", 32'(carry_out), 32'd0);
            chk_drives_zero("abort");
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("abort.nodone", 32'(done), 32'd0);
            chk("abort.idle", 32'(busy), 32'd0);
            return;
         end
         if (i == glitch_step) begin
            start = 1'b1;
            a = '1;
         end else begin
            start = 1'b0;
         end
         flip = (i == flip_step);
         chk("run.busy", 32'(busy), 32'd1);
         chk("run.done", 32'(done), 32'd0);
         chk("run.fin", 32'(cell_fin), 32'(ta[i]));
         chk("run.pin", 32'(cell_pin), 32'(tbv[i]));
         chk("run.cin", 32'(cell_cin), 32'(c));
         chk("run.m", 32'(cell_m), 32'(tm));
         chk("run.err", 32'(err), 32'((flip_step >= 0) && (i > flip_step)));
         c = (ta[i] & tbv[i]) | (ta[i] & c) | (tbv[i] & c);
         @(negedge clk);
      end
      flip = 1'b0;
      start = 1'b0;
      sum = (N+1)'(ta) + (N+1)'(tbv) + (N+1)'(tc);
      chk("done.pulse", 32'(done), 32'd1);
      chk("done.busy", 32'(busy), 32'd0);
      chk("done.result", 32'(result), 32'(sum[N-1:0]));
      chk("done.carry", 32'(carry_out), 32'(sum[N]));
      chk("done.err", 32'(err), 32'(flip_step >= 0));
      chk_drives_zero("done");
      res_hold = sum[N-1:0];
      @(negedge clk);
      chk("idle.done", 32'(done), 32'd0);
      chk("idle.busy", 32'(busy), 32'd0);
      chk("idle.result", 32'(result), 32'(res_hold));
      chk("idle.carry", 32'(carry_out), 32'(sum[N]));
      chk("idle.err", 32'(err), 32'(flip_step >= 0));
      chk_drives_zero("idle");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = '0; cin0 = 1'b0; a = '0; b = '0; flip = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      chk("reset.result", 32'(result), 32'd0);
      chk("reset.carry", 32'(carry_out), 32'd0);
      chk("reset.err", 32'(err), 32'd0);
      chk_drives_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Directed cases
      run_op(4'hB, 4'h6, 1'b0, 2'd0, -1, -1, -1);
      run_op(4'hF, 4'h0, 1'b1, 2'd3, -1, -1, -1);
      run_op(4'h3, 4'h1, 1'b0, 2'd0, -1,  1, -1);
      run_op(4'h9, 4'h7, 1'b1, 2'd2, -1, -1,  1);
      run_op(4'h5, 4'h5, 1'b0, 2'd0, -1, -1, -1);
      run_op(4'h2, 4'hC, 1'b0, 2'd1,  2, -1, -1);
      run_op(4'h2, 4'hC, 1'b0, 2'd1, -1, -1, -1);

      // Randomized operations
      for (int k = 0; k < 40; k++) begin
         int fs;
         fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
         run_op(N'($urandom), N'($urandom), 1'($urandom), 2'($urandom), fs, -1, -1);
      end

      // start held high: DONE goes straight back to RUN
      @(negedge clk);
      a = 4'h1; b = 4'h1; cin0 = 1'b0; mode = 2'd0; start = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < int'(N); i++) begin
            chk("b2b.busy", 32'(busy), 32'd1);
            @(negedge clk);
         end
         chk("b2b.done", 32'(done), 32'd1);
         chk("b2b.result", 32'(result), 32'h2);
         chk("b2b.carry", 32'(carry_out), 32'd0);
         if (r == 2) start = 1'b0;
         @(negedge clk);
      end
      chk("b2b.end.busy", 32'(busy), 32'd0);
      chk("b2b.end.done", 32'(done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
